// File: rtl/sram_mem_ctrl_pkg.sv
// Shared types and constants for the 16-bit SRAM word-access controller.
package sram_mem_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LO,
    HI,
    WAIT,
    DONE
  } state_e;

  typedef enum logic {
    OP_RD,
    OP_WR
  } op_e;

  localparam logic HALF_LO = 1'b0;
  localparam logic HALF_HI = 1'b1;

  localparam int unsigned CNT_W  = 4;
  localparam int unsigned HALF_W = 16;

endpackage

// File: rtl/sram_wait_counter.sv
// Loadable down-counter; done is high while the count sits at zero.
module sram_wait_counter
  import sram_mem_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             en,
  input  logic [CNT_W-1:0] loadVal,
  output logic             done
);

  logic [CNT_W-1:0] count;

  // done is registered alongside the count so it marks the final wait cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      done  <= 1'b1;
    end else if (load) begin
      count <= loadVal;
      done  <= (loadVal == '0);
    end else if (en && (count != '0)) begin
      count <= count - CNT_W'(1);
      done  <= (count == CNT_W'(1));
    end
  end

endmodule

// File: rtl/sram_mem_ctrl.sv
// MEM-stage responder serving 32-bit words from a 16-bit SRAM in two beats plus wait states.
// Optional read-hit shortcut enabled by defining SRAM_MEM_CTRL_READ_HIT_EN.
module sram_mem_ctrl
  import sram_mem_ctrl_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 5,
  parameter int unsigned SRAM_AW     = 18,
  parameter int unsigned BASE_ADDR   = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rd_en,
  input  logic               wr_en,
  input  logic [31:0]        address,
  input  logic [31:0]        wdata,
  output logic [31:0]        rdata,
  output logic               ready,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [HALF_W-1:0]  sram_dq_out,
  output logic               sram_dq_oe,
  input  logic [HALF_W-1:0]  sram_dq_in,
  output logic               sram_we_n
);

  localparam int unsigned      IDX_W     = SRAM_AW - 1;
  localparam bit               HAS_WAIT  = (WAIT_CYCLES > 2);
  localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'((WAIT_CYCLES > 2) ? (WAIT_CYCLES - 3) : 0);

  state_e            state;
  op_e               op;
  op_e               reqOp;
  logic              reqAny;
  logic [IDX_W-1:0]  reqIdx;
  logic [IDX_W-1:0]  idx;
  logic [HALF_W-1:0] loQ;
  logic [HALF_W-1:0] hiQ;
  logic [HALF_W-1:0] hiWord;
  logic [HALF_W-1:0] wdataHi;
  logic              cntLoad;
  logic              cntEn;
  logic              cntDone;
  logic              readDone;
  logic              readHit;

  assign reqAny = rd_en | wr_en;
  assign reqOp  = wr_en ? OP_WR : OP_RD;
  assign reqIdx = IDX_W'((address - BASE_ADDR) >> 2);

  // ready is combinational on the request in IDLE so the pipeline freezes in the same cycle
  assign ready = (state == DONE) || ((state == IDLE) && !reqAny);

  assign cntLoad  = (state == HI) && HAS_WAIT;
  assign cntEn    = (state == WAIT);
  assign readDone = (op == OP_RD) &&
                    (((state == HI) && !HAS_WAIT) || ((state == WAIT) && cntDone));
  assign hiWord   = (state == HI) ? sram_dq_in : hiQ;

  sram_wait_counter waitCnt (
    .clk     (clk),
    .rst_n   (rst),
    .load    (cntLoad),
    .en      (cntEn),
    .loadVal (WAIT_LOAD),
    .done    (cntDone)
  );

`ifdef SRAM_MEM_CTRL_READ_HIT_EN
  logic             tagValid;
  logic [IDX_W-1:0] tagIdx;

  assign readHit = tagValid && (tagIdx == reqIdx);

  // Tag tracks the last completed read; a write to that word invalidates it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tagValid <= 1'b0;
      tagIdx   <= '0;
    end else if ((state == IDLE) && wr_en && (reqIdx == tagIdx)) begin
      tagValid <= 1'b0;
    end else if (readDone) begin
      tagValid <= 1'b1;
      tagIdx   <= idx;
    end
  end
`else
  assign readHit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      op          <= OP_RD;
      idx         <= '0;
      loQ         <= '0;
      hiQ         <= '0;
      wdataHi     <= '0;
      rdata       <= '0;
      sram_addr   <= '0;
      sram_dq_out <= '0;
      sram_dq_oe  <= 1'b0;
      sram_we_n   <= 1'b1;
    end else begin
      if (readDone) begin
        rdata <= {hiWord, loQ};
      end
      case (state)
        IDLE: begin
          if (reqAny) begin
            op      <= reqOp;
            idx     <= reqIdx;
            wdataHi <= wdata[31:16];
            if (!wr_en && readHit) begin
              state <= DONE;
            end else begin
              state     <= LO;
              sram_addr <= {reqIdx, HALF_LO};
              if (wr_en) begin
                sram_dq_out <= wdata[15:0];
                sram_dq_oe  <= 1'b1;
                sram_we_n   <= 1'b0;
              end
            end
          end
        end
        LO: begin
          state     <= HI;
          sram_addr <= {idx, HALF_HI};
          if (op == OP_WR) begin
            sram_dq_out <= wdataHi;
          end else begin
            loQ <= sram_dq_in;
          end
        end
        HI: begin
          sram_dq_oe <= 1'b0;
          sram_we_n  <= 1'b1;
          if (op == OP_RD) begin
            hiQ <= sram_dq_in;
          end
          state <= HAS_WAIT ? WAIT : DONE;
        end
        WAIT: begin
          if (cntDone) begin
            state <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
